// File: rtl/seg_red_unit.sv
// Pipelined segmented reduction: LGN-stage segmented inclusive scan over N lanes,
// then a scatter/accumulate register that writes each segment sum to its output slot.
module seg_red_unit #(
  parameter int N = 16,
  parameter int W = 8,
  localparam int LGN = $clog2(N)
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [N-1:0][W-1:0]       in_data_i,
  input  logic [N-1:0]              in_split_i,
  input  logic [N-1:0][LGN-1:0]     in_out_idx_i,
  input  logic                      in_acc_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [N-1:0][W-1:0]       out_data_o,
  output logic [N-1:0]              out_wmask_o,
  output logic [31:0]               delay_o,
  output logic [31:0]               num_el_o
);

  logic                  stall, adv, rdy_q;
  logic [LGN:0]          vld_q;
  logic [N-1:0]          spl_in;

  // st_* is the input of scan stage s, *_d its result, *_q its register
  logic [N-1:0][W-1:0]   st_sum [LGN];
  logic [N-1:0][W-1:0]   sum_d  [LGN];
  logic [N-1:0][W-1:0]   sum_q  [LGN];
  logic [N-1:0]          st_hd  [LGN];
  logic [N-1:0]          hd_d   [LGN];
  logic [N-1:0]          hd_q   [LGN];
  logic [N-1:0]          spl_q  [LGN];
  logic [N-1:0][LGN-1:0] idx_q  [LGN];
  logic [LGN-1:0]        acc_q;

  logic [N-1:0][W-1:0]   wr_val, out_data_d, out_data_q;
  logic [N-1:0]          out_wmask_d, out_wmask_q;

  assign stall       = vld_q[LGN] && !out_ready_i;
  assign adv         = !stall;
  assign in_ready_o  = rdy_q && !stall;
  assign out_valid_o = vld_q[LGN];
  assign out_data_o  = out_data_q;
  assign out_wmask_o = out_wmask_q;
  assign delay_o     = 32'(LGN + 1);
  assign num_el_o    = 32'(N);

  // hd[i]=1 means sum[i] already reaches back to the first lane of its segment
  always_comb begin
    spl_in        = in_split_i;
    spl_in[N-1]   = 1'b1;
    st_sum[0]     = in_data_i;
    st_hd[0]      = {spl_in[N-2:0], 1'b1};
    for (int s = 1; s < LGN; s++) begin
      st_sum[s] = sum_q[s-1];
      st_hd[s]  = hd_q[s-1];
    end
    for (int s = 0; s < LGN; s++) begin
      sum_d[s] = st_sum[s];
      hd_d[s]  = st_hd[s];
      for (int i = (1 << s); i < N; i++) begin
        if (!st_hd[s][i]) begin
          sum_d[s][i] = st_sum[s][i] + st_sum[s][i-(1<<s)];
          hd_d[s][i]  = st_hd[s][i-(1<<s)];
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (adv) begin
      spl_q[0] <= spl_in;
      idx_q[0] <= in_out_idx_i;
      acc_q[0] <= in_acc_i;
      for (int s = 0; s < LGN; s++) begin
        sum_q[s] <= sum_d[s];
        hd_q[s]  <= hd_d[s];
      end
      for (int s = 1; s < LGN; s++) begin
        spl_q[s] <= spl_q[s-1];
        idx_q[s] <= idx_q[s-1];
        acc_q[s] <= acc_q[s-1];
      end
    end
  end

  // Ascending lane order lets the highest lane win on duplicate slots
  always_comb begin
    wr_val      = '0;
    out_wmask_d = '0;
    for (int i = 0; i < N; i++) begin
      if (spl_q[LGN-1][i]) begin
        out_wmask_d[idx_q[LGN-1][i]] = 1'b1;
        wr_val[idx_q[LGN-1][i]]      = sum_q[LGN-1][i];
      end
    end
    for (int j = 0; j < N; j++) begin
      if (acc_q[LGN-1])
        out_data_d[j] = out_wmask_d[j] ? out_data_q[j] + wr_val[j] : out_data_q[j];
      else
        out_data_d[j] = out_wmask_d[j] ? wr_val[j] : '0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rdy_q       <= 1'b0;
      vld_q       <= '0;
      out_data_q  <= '0;
      out_wmask_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (adv) begin
        vld_q <= {vld_q[LGN-1:0], in_valid_i && in_ready_o};
        if (vld_q[LGN-1]) begin
          out_data_q  <= out_data_d;
          out_wmask_q <= out_wmask_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_red_unit.sv
// Directed bench for seg_red_unit (N=16, W=8): hand-computed segment sums, latency,
// stall behaviour, accumulation wrap and asynchronous reset.
module tb_seg_red_unit;
  localparam int N = 16, W = 8, LGN = 4;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic                  in_valid = 1'b0, in_acc = 1'b0, out_ready = 1'b1;
  logic                  in_ready, out_valid;
  logic [N-1:0][W-1:0]   in_data = '0, out_data;
  logic [N-1:0]          in_split = '0, out_wmask;
  logic [N-1:0][LGN-1:0] in_idx = '0;
  logic [31:0]           delay, num_el;

  int checks = 0, errors = 0;
  int n, sent, rcv;
  logic bad;
  logic [N-1:0][W-1:0] e;

  seg_red_unit #(.N(N), .W(W)) dut (
    .clock_i(clk), .reset_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_split_i(in_split), .in_out_idx_i(in_idx), .in_acc_i(in_acc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_wmask_o(out_wmask),
    .delay_o(delay), .num_el_o(num_el)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents the current inputs for one edge, then waits (bounded) for out_valid
  task automatic wait_out(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
      in_valid = 1'b0;
    end while (!out_valid && cnt < 20);
  endtask

  initial begin
    // reset state
    repeat (2) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_wmask", out_wmask, 0);
    chk("rst_ready", in_ready, 0);
    chk("delay", delay, 5);
    chk("num_el", num_el, 16);
    rst = 1'b0;
    #1 chk("rdy_after_rel", in_ready, 0);
    step();
    chk("rdy_one_later", in_ready, 1);

    // 1: one segment across all lanes, forced split on lane 15
    for (int i = 0; i < N; i++) in_data[i] = 8'd1;
    in_split = '0; in_idx = '0; in_idx[15] = 4'd3; in_acc = 1'b0;
    in_valid = 1'b1;
    wait_out(n);
    chk("t1_latency", n, 5);
    e = '0; e[3] = 8'd16;
    chk("t1_data", out_data, e);
    chk("t1_wmask", out_wmask, 16'h0008);
    step();
    chk("t1_vld_drop", out_valid, 0);
    chk("t1_hold", out_data, e);

    // 2: every lane its own segment, reversed slots
    for (int i = 0; i < N; i++) begin
      in_data[i] = 8'(i); in_idx[i] = 4'(15 - i);
    end
    in_split = '1; in_valid = 1'b1;
    wait_out(n);
    for (int j = 0; j < N; j++) e[j] = 8'(15 - j);
    chk("t2_data", out_data, e);
    chk("t2_wmask", out_wmask, 16'hFFFF);

    // 3: three segments; idx of non-split lanes must be ignored
    for (int i = 0; i < N; i++) begin
      in_data[i] = 8'd2; in_idx[i] = 4'd9;
    end
    in_split = 16'h8088; in_idx[3] = 4'd0; in_idx[7] = 4'd1; in_idx[15] = 4'd2;
    in_valid = 1'b1;
    wait_out(n);
    e = '0; e[0] = 8'd8; e[1] = 8'd8; e[2] = 8'd16;
    chk("t3_data", out_data, e);
    chk("t3_wmask", out_wmask, 16'h0007);

    // duplicate slot: highest lane wins
    for (int i = 0; i < N; i++) begin
      in_data[i] = 8'(i + 1); in_idx[i] = 4'd4;
    end
    in_split = '1; in_valid = 1'b1;
    wait_out(n);
    e = '0; e[4] = 8'd16;
    chk("dup_data", out_data, e);
    chk("dup_wmask", out_wmask, 16'h0010);

    // 4: beat A replaces, beat B back-to-back accumulates with wrap
    for (int i = 0; i < N; i++) in_data[i] = (i < 8) ? 8'd25 : 8'd3;
    in_split = 16'h8080; in_idx = '0; in_idx[7] = 4'd5; in_idx[15] = 4'd9; in_acc = 1'b0;
    in_valid = 1'b1;
    step();
    in_data = '0; in_data[0] = 8'd100;
    in_split = '0; in_idx = '0; in_idx[15] = 4'd5; in_acc = 1'b1;
    wait_out(n);
    e = '0; e[5] = 8'd200; e[9] = 8'd24;
    chk("t4a_data", out_data, e);
    chk("t4a_wmask", out_wmask, 16'h0220);
    step();
    e[5] = 8'd44;
    chk("t4b_valid", out_valid, 1);
    chk("t4b_data", out_data, e);
    chk("t4b_wmask", out_wmask, 16'h0020);
    in_acc = 1'b0;
    step();

    // 5: 8 beats streamed, consumer stalls for cycles 7..9
    sent = 0; rcv = 0;
    in_split = '1;
    for (int i = 0; i < N; i++) in_idx[i] = 4'(i);
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 7 && c <= 9);
      in_valid  = (sent < 8);
      for (int i = 0; i < N; i++) in_data[i] = 8'(sent * 16 + i);
      #1;
      chk("t5_in_ready", in_ready, !(c >= 7 && c <= 9));
      if (out_valid && out_ready) begin
        for (int i = 0; i < N; i++) e[i] = 8'(rcv * 16 + i);
        chk("t5_order", out_data, e);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t5_sent", sent, 8);
    chk("t5_rcvd", rcv, 8);

    // 6: asynchronous reset with three beats in flight
    for (int i = 0; i < N; i++) in_data[i] = 8'd7;
    in_valid = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_data", out_data, 0);
    chk("t6_wmask", out_wmask, 0);
    step();
    rst = 1'b0;
    #1 chk("t6_rdy_rel", in_ready, 0);
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      bad |= out_valid;
    end
    chk("t6_no_stale", bad, 0);
    chk("t6_rdy", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
